dpram_port_arbiter: RTL and testbench
=====================================

DPRAM_PORT_ARBITER -- requirements
Module: dpram_port_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data width of requests and memory.
REQ-002 Parameter ADDR_WIDTH, default 3, address width; DEPTH = 2**ADDR_WIDTH.
REQ-003 Parameter READ_LATENCY, default 2, cycles from memory command to valid i_mem_dout; legal range 1..4.
REQ-004 Parameter WRITE_LATENCY, default 1, cycles from write command until the written data is readable; legal range 1..4.
REQ-005 i_clk  input  1  single clock; all logic on its rising edge.
REQ-006 i_rst  input  1  reset, asynchronous and active-high.
REQ-007 i_req_valid_0 / i_req_valid_1  input  1  requester 0/1 command valid.
REQ-008 i_req_we_0 / i_req_we_1  input  1  1 = write, 0 = read.
REQ-009 i_req_addr_0 / i_req_addr_1  input  ADDR_WIDTH  command address.
REQ-010 i_req_din_0 / i_req_din_1  input  WIDTH  write data.
REQ-011 o_req_ready_0 / o_req_ready_1  output  1  command accepted this cycle when valid and ready are both high.
REQ-012 o_rsp_valid_0 / o_rsp_valid_1  output  1  read data valid for that requester, one-cycle pulse.
REQ-013 o_rsp_data_0 / o_rsp_data_1  output  WIDTH  read data.
REQ-014 o_mem_en, o_mem_we  output  1  memory port enable and write enable.
REQ-015 o_mem_addr  output  ADDR_WIDTH; o_mem_din  output  WIDTH; i_mem_dout  input  WIDTH.

Function
REQ-016 At most one requester SHALL be granted per cycle; o_req_ready_x SHALL be high only for the granted requester and SHALL depend combinationally on the request valids, the arbitration pointer and the hazard state.
REQ-017 Arbitration SHALL be round-robin: a lone valid requester wins; with both valid, the requester not accepted most recently wins; the pointer SHALL update only on an accept.
REQ-018 Memory commands SHALL be registered: an accept in cycle N drives o_mem_en=1 and the selected we/addr/din in cycle N+1; otherwise o_mem_en=0 and o_mem_we=0.
REQ-019 A read accepted in cycle N SHALL produce o_rsp_valid_x=1 with o_rsp_data_x=i_mem_dout in cycle N+1+READ_LATENCY, tagged to the originating requester by a READ_LATENCY-deep {valid, id} shift pipeline.
REQ-020 Writes SHALL produce no response.
REQ-021 Read-after-write hazard: a read whose address equals a write issued to memory within the last WRITE_LATENCY cycles, or accepted in the current cycle, SHALL NOT be granted; the other requester MAY be granted in that cycle.
REQ-022 Back-to-back accepts every cycle SHALL be supported; throughput is one command per cycle absent hazards.
REQ-023 Requesters hold valid and payload stable until accepted; the block need not tolerate withdrawal.
REQ-024 o_rsp_data_x SHALL hold its last value when o_rsp_valid_x is low.

Reset
REQ-025 While i_rst is high: all ready, rsp_valid, mem_en and mem_we outputs = 0; o_mem_addr, o_mem_din and o_rsp_data_x = 0; the read pipeline and hazard scoreboard are cleared; the pointer is set so that requester 0 wins the first contention.
REQ-026 Reads in flight at reset assertion SHALL be discarded and produce no response after reset release.

Structure
REQ-027 Package dpram_arb_pkg SHALL hold NUM_REQ=2, typedef req_id_t, and the struct rd_tag_t {valid, id}.
REQ-028 Sub-module rr_arbiter2 SHALL implement the two-way round-robin grant and pointer; hazard checking, the command register and the response pipeline stay in the top module.

Verification
REQ-029 Reset, then requester 0 writes 0x0C to addr 0 (no contention) -> ready_0=1 in the request cycle; next cycle mem_en=1, mem_we=1, addr=0, din=0x0C.
REQ-030 Both requesters valid for 4 cycles, reads to addr 1 and addr 2 -> grant order 0,1,0,1; rsp_valid_0 and rsp_valid_1 alternate, each 1+READ_LATENCY cycles after its accept, with the correct data.
REQ-031 Requester 0 writes 0x0D to addr 3; requester 1 reads addr 3 in the next cycle -> ready_1 is held low for WRITE_LATENCY cycles, then the read returns 0x0D.
REQ-032 Requester 1 streams 6 reads to addrs 0..5 alone -> one accept per cycle; 6 consecutive rsp_valid_1 pulses in address order.
REQ-033 Assert i_rst asynchronously (mid-cycle) while 2 reads are in flight -> outputs go to 0 immediately; no rsp_valid after release; the first post-reset contention grants requester 0.

Source files
------------

// File: rtl/dpram_arb_pkg.sv
// dpram_arb_pkg: shared types for the dual-port RAM arbiter.
package dpram_arb_pkg;
    localparam int NUM_REQ = 2;
    typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_tag_t;
endpackage

// File: rtl/dpram_port_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant with a pointer that moves only on an accept.
module rr_arbiter2
    import dpram_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);
    // prio names the requester that wins the next contention
    logic prio;
    assign grant[0] = req[0] && (!req[1] || !prio);
    assign grant[1] = req[1] && (!req[0] || prio);
    always_ff @(posedge clk or posedge rst)
        if (rst)
            prio <= 1'b0;
        else if (|grant)
            prio <= grant[0];
endmodule

// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter: shares one memory port between two requesters with
// round-robin grant, read-after-write blocking and tagged read responses.
module dpram_port_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int ADDR_WIDTH    = 3,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid_0,
    input  logic                  i_req_valid_1,
    input  logic                  i_req_we_0,
    input  logic                  i_req_we_1,
    input  logic [ADDR_WIDTH-1:0] i_req_addr_0,
    input  logic [ADDR_WIDTH-1:0] i_req_addr_1,
    input  logic [WIDTH-1:0]      i_req_din_0,
    input  logic [WIDTH-1:0]      i_req_din_1,
    output logic                  o_req_ready_0,
    output logic                  o_req_ready_1,
    output logic                  o_rsp_valid_0,
    output logic                  o_rsp_valid_1,
    output logic [WIDTH-1:0]      o_rsp_data_0,
    output logic [WIDTH-1:0]      o_rsp_data_1,
    output logic                  o_mem_en,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [WIDTH-1:0]      o_mem_din,
    input  logic [WIDTH-1:0]      i_mem_dout
);
    logic [NUM_REQ-1:0]    valid, is_rd, hazard, eligible, grant;
    logic [ADDR_WIDTH-1:0] addr [NUM_REQ];
    logic [WIDTH-1:0]      din [NUM_REQ];
    logic [WRITE_LATENCY-1:0] wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr [WRITE_LATENCY];
    rd_tag_t               tag [READ_LATENCY];
    rd_tag_t               out_tag;
    req_id_t               sel, cmd_id;
    logic                  accept;
    logic [WIDTH-1:0]      hold_0, hold_1;

    assign valid   = {i_req_valid_1, i_req_valid_0};
    assign is_rd   = {!i_req_we_1, !i_req_we_0};
    assign addr[0] = i_req_addr_0;
    assign addr[1] = i_req_addr_1;
    assign din[0]  = i_req_din_0;
    assign din[1]  = i_req_din_1;

    // wr_* holds the writes issued in the last WRITE_LATENCY cycles, newest at index 0
    always_comb begin
        hazard = '0;
        for (int r = 0; r < NUM_REQ; r++)
            for (int k = 0; k < WRITE_LATENCY; k++)
                if (is_rd[r] && wr_valid[k] && wr_addr[k] == addr[r])
                    hazard[r] = 1'b1;
    end

    assign eligible = valid & ~hazard & {NUM_REQ{!i_rst}};

    rr_arbiter2 u_rr (
        .clk   (i_clk),
        .rst   (i_rst),
        .req   (eligible),
        .grant (grant)
    );

    assign sel           = grant[1];
    assign accept        = |grant;
    assign o_req_ready_0 = grant[0];
    assign o_req_ready_1 = grant[1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_mem_en   <= 1'b0;
            o_mem_we   <= 1'b0;
            o_mem_addr <= '0;
            o_mem_din  <= '0;
            cmd_id     <= '0;
            wr_valid   <= '0;
            for (int k = 0; k < WRITE_LATENCY; k++)
                wr_addr[k] <= '0;
            for (int k = 0; k < READ_LATENCY; k++)
                tag[k] <= '0;
        end else begin
            o_mem_en <= accept;
            o_mem_we <= accept && !is_rd[sel];
            if (accept) begin
                o_mem_addr <= addr[sel];
                o_mem_din  <= din[sel];
                cmd_id     <= sel;
            end
            wr_valid[0] <= accept && !is_rd[sel];
            wr_addr[0]  <= addr[sel];
            for (int k = 1; k < WRITE_LATENCY; k++) begin
                wr_valid[k] <= wr_valid[k-1];
                wr_addr[k]  <= wr_addr[k-1];
            end
            tag[0] <= {o_mem_en && !o_mem_we, cmd_id};
            for (int k = 1; k < READ_LATENCY; k++)
                tag[k] <= tag[k-1];
        end
    end

    assign out_tag       = tag[READ_LATENCY-1];
    assign o_rsp_valid_0 = out_tag.valid && out_tag.id == req_id_t'(0);
    assign o_rsp_valid_1 = out_tag.valid && out_tag.id == req_id_t'(1);
    assign o_rsp_data_0  = o_rsp_valid_0 ? i_mem_dout : hold_0;
    assign o_rsp_data_1  = o_rsp_valid_1 ? i_mem_dout : hold_1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hold_0 <= '0;
            hold_1 <= '0;
        end else begin
            if (o_rsp_valid_0)
                hold_0 <= i_mem_dout;
            if (o_rsp_valid_1)
                hold_1 <= i_mem_dout;
        end
    end
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb_dpram_port_arbiter: directed stimulus with a response scoreboard against a reference memory.
module tb_dpram_port_arbiter;
    localparam int W     = 8;
    localparam int AW    = 3;
    localparam int RL    = 2;
    localparam int WL    = 1;
    localparam int DEPTH = 2**AW;

    logic          i_clk = 1'b0, i_rst = 1'b1;
    logic          i_req_valid_0 = 0, i_req_valid_1 = 0, i_req_we_0 = 0, i_req_we_1 = 0;
    logic [AW-1:0] i_req_addr_0 = '0, i_req_addr_1 = '0;
    logic [W-1:0]  i_req_din_0 = '0, i_req_din_1 = '0;
    logic          o_req_ready_0, o_req_ready_1, o_rsp_valid_0, o_rsp_valid_1;
    logic [W-1:0]  o_rsp_data_0, o_rsp_data_1;
    logic          o_mem_en, o_mem_we;
    logic [AW-1:0] o_mem_addr;
    logic [W-1:0]  o_mem_din, i_mem_dout;

    dpram_port_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .WRITE_LATENCY(WL)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid_0(i_req_valid_0), .i_req_valid_1(i_req_valid_1),
        .i_req_we_0(i_req_we_0), .i_req_we_1(i_req_we_1),
        .i_req_addr_0(i_req_addr_0), .i_req_addr_1(i_req_addr_1),
        .i_req_din_0(i_req_din_0), .i_req_din_1(i_req_din_1),
        .o_req_ready_0(o_req_ready_0), .o_req_ready_1(o_req_ready_1),
        .o_rsp_valid_0(o_rsp_valid_0), .o_rsp_valid_1(o_rsp_valid_1),
        .o_rsp_data_0(o_rsp_data_0), .o_rsp_data_1(o_rsp_data_1),
        .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_din(o_mem_din), .i_mem_dout(i_mem_dout)
    );

    always #5 i_clk = ~i_clk;

    int total = 0, bad = 0, cyc = 0, rsp_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // memory the DUT drives: writes land at the end of the command cycle,
    // read data appears RL cycles after the command
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rd_pipe [RL];
    initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    always @(posedge i_clk) begin
        if (o_mem_en && o_mem_we) mem[o_mem_addr] <= o_mem_din;
        rd_pipe[0] <= mem[o_mem_addr];
        for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign i_mem_dout = rd_pipe[RL-1];

    always @(posedge i_clk) cyc++;

    typedef struct {
        logic [W-1:0] data;
        int           due;
    } exp_t;
    exp_t q0[$], q1[$];
    logic [W-1:0] ref_mem [DEPTH];
    logic [W-1:0] last_d [2];
    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        last_d[0] = '0;
        last_d[1] = '0;
    end

    task automatic note_accept(input int r, input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
        exp_t e;
        if (we) ref_mem[a] = d;
        else begin
            e.data = ref_mem[a];
            e.due  = cyc + 1 + RL;
            if (r == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    task automatic take_rsp(input int r, input logic v, input logic [W-1:0] d);
        exp_t e;
        rsp_cnt++;
        if ((r == 0 ? q0.size() : q1.size()) == 0) begin
            chk($sformatf("rsp%0d_unexpected", r), {31'b0, v}, 0);
            return;
        end
        e = (r == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("rsp%0d_data", r), d, e.data);
        chk($sformatf("rsp%0d_cycle", r), cyc, e.due);
        last_d[r] = d;
    endtask

    always @(negedge i_clk) begin
        if (i_rst) begin
            last_d[0] = '0;
            last_d[1] = '0;
        end
        if (o_rsp_valid_0) take_rsp(0, o_rsp_valid_0, o_rsp_data_0);
        else chk("rsp0_hold", o_rsp_data_0, last_d[0]);
        if (o_rsp_valid_1) take_rsp(1, o_rsp_valid_1, o_rsp_data_1);
        else chk("rsp1_hold", o_rsp_data_1, last_d[1]);
        if (o_req_ready_0 && o_req_ready_1) chk("single_grant", 2'b11, 2'b01);
        if (i_req_valid_0 && o_req_ready_0) note_accept(0, i_req_we_0, i_req_addr_0, i_req_din_0);
        if (i_req_valid_1 && o_req_ready_1) note_accept(1, i_req_we_1, i_req_addr_1, i_req_din_1);
    end

    task automatic set(input int r, input logic v, input logic we, input logic [AW-1:0] a, input logic [W-1:0] d);
        if (r == 0) begin
            i_req_valid_0 = v; i_req_we_0 = we; i_req_addr_0 = a; i_req_din_0 = d;
        end else begin
            i_req_valid_1 = v; i_req_we_1 = we; i_req_addr_1 = a; i_req_din_1 = d;
        end
    endtask

    task automatic idle(input int r);
        set(r, 0, 0, '0, '0);
    endtask

    // present a command and return after the accepting edge, reporting stalled cycles
    task automatic issue(input int r, input logic we, input logic [AW-1:0] a, input logic [W-1:0] d, output int waits);
        logic rdy;
        set(r, 1, we, a, d);
        waits = 0;
        forever begin
            @(negedge i_clk);
            rdy = (r == 0) ? o_req_ready_0 : o_req_ready_1;
            if (rdy || waits > 20) break;
            waits++;
        end
        if (!rdy) chk($sformatf("accept%0d_timeout", r), {31'b0, rdy}, 1);
        @(posedge i_clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int w, base;
        set(0, 1, 0, 3'd2, '0);
        #3;
        chk("rst_ready0", o_req_ready_0, 0);
        chk("rst_mem_en", o_mem_en, 0);
        chk("rst_mem_we", o_mem_we, 0);
        chk("rst_mem_addr", o_mem_addr, 0);
        chk("rst_rsp_valid", {o_rsp_valid_1, o_rsp_valid_0}, 0);
        idle(0);
        repeat (2) @(negedge i_clk);
        i_rst = 0;
        @(posedge i_clk); #1;

        set(0, 1, 1, 3'd0, 8'h0C);
        @(negedge i_clk);
        chk("wr_ready0", o_req_ready_0, 1);
        chk("wr_ready1", o_req_ready_1, 0);
        @(posedge i_clk); #1;
        idle(0);
        @(negedge i_clk);
        chk("wr_mem_en", o_mem_en, 1);
        chk("wr_mem_we", o_mem_we, 1);
        chk("wr_mem_addr", o_mem_addr, 0);
        chk("wr_mem_din", o_mem_din, 8'h0C);
        @(posedge i_clk); #1;

        for (int a = 1; a < 6; a++) begin
            issue(1, 1, AW'(a), 8'(8'h10 + a), w);
            chk("fill_no_stall", w, 0);
        end
        idle(1);

        set(0, 1, 0, 3'd1, '0);
        set(1, 1, 0, 3'd2, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            chk($sformatf("rr%0d_ready0", i), o_req_ready_0, (i % 2) == 0);
            chk($sformatf("rr%0d_ready1", i), o_req_ready_1, (i % 2) == 1);
            @(posedge i_clk); #1;
        end
        idle(0);
        idle(1);
        repeat (RL + 3) @(negedge i_clk);
        @(posedge i_clk); #1;

        issue(0, 1, 3'd3, 8'h0D, w);
        idle(0);
        set(1, 1, 0, 3'd3, '0);
        for (int k = 0; k < WL; k++) begin
            @(negedge i_clk);
            chk("raw_blocked", o_req_ready_1, 0);
            @(posedge i_clk); #1;
        end
        @(negedge i_clk);
        chk("raw_released", o_req_ready_1, 1);
        @(posedge i_clk); #1;
        idle(1);
        repeat (RL + 3) @(negedge i_clk);
        @(posedge i_clk); #1;

        base = rsp_cnt;
        for (int a = 0; a < 6; a++) begin
            issue(1, 0, AW'(a), '0, w);
            chk("stream_no_stall", w, 0);
        end
        idle(1);
        repeat (RL + 3) @(negedge i_clk);
        chk("stream_rsp_count", rsp_cnt - base, 6);
        @(posedge i_clk); #1;

        issue(1, 0, 3'd2, '0, w);
        idle(1);
        issue(0, 0, 3'd1, '0, w);
        idle(0);
        #2;
        i_rst = 1;
        q0.delete();
        q1.delete();
        #1;
        chk("async_mem_en", o_mem_en, 0);
        chk("async_mem_din", o_mem_din, 0);
        chk("async_rsp_valid", {o_rsp_valid_1, o_rsp_valid_0}, 0);
        chk("async_rsp_data", {o_rsp_data_1, o_rsp_data_0}, 0);
        repeat (2) @(negedge i_clk);
        i_rst = 0;
        base = rsp_cnt;
        repeat (6) @(negedge i_clk);
        chk("no_stale_rsp", rsp_cnt - base, 0);
        @(posedge i_clk); #1;

        set(0, 1, 0, 3'd4, '0);
        set(1, 1, 0, 3'd5, '0);
        @(negedge i_clk);
        chk("post_rst_ready0", o_req_ready_0, 1);
        chk("post_rst_ready1", o_req_ready_1, 0);
        @(posedge i_clk); #1;
        idle(0);
        @(negedge i_clk);
        chk("post_rst_next1", o_req_ready_1, 1);
        @(posedge i_clk); #1;
        idle(1);
        repeat (RL + 4) @(negedge i_clk);
        chk("sb_drained", q0.size() + q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
